game_tick_scheduler: RTL and testbench

Sequences Conway generation updates. It decides when the board-update engine computes the next generation, at a user-selected rate. A phase accumulator produces rate ticks at one of 10 speeds, and run/pause/single-step buttons control it. A start/done handshake with the update engine ensures only one generation is in flight, and ticks that arrive while the engine is busy are counted as overruns.

---
 rtl/game_pkg.sv | 32 +++
 rtl/btn_edge_sync.sv | 27 ++
 rtl/game_tick_scheduler.sv | 162 ++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, speed table and FSM state type for the Conway tick scheduler.
package game_pkg;

    localparam int unsigned PERIOD_DEFAULT = 50_000_000;
    localparam int unsigned ACC_W_DEFAULT  = 32;
    localparam int unsigned SPEED_W        = 4;
    localparam int unsigned FPS_W          = 8;
    localparam int unsigned NUM_SPEEDS     = 10;
    localparam int unsigned SPEED_LAST     = 9;

    // Entry 0 sits in the least significant byte.
    localparam logic [NUM_SPEEDS*FPS_W-1:0] SPEED_TABLE = {
        8'd255, 8'd199, 8'd127, 8'd63, 8'd31,
        8'd15,  8'd9,   8'd5,   8'd3,  8'd1
    };

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        RUN_WAIT = 2'd1,
        BUSY     = 2'd2
    } state_e;

    function automatic logic [FPS_W-1:0] speed_inc(input logic [SPEED_W-1:0] idx);
        logic [6:0] base;
        base = {idx, 3'b000};
        if (idx > SPEED_W'(SPEED_LAST)) begin
            return FPS_W'(1);
        end
        return SPEED_TABLE[base +: FPS_W];
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for a raw button.
module btn_edge_sync (
    input  logic cin,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_c_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_c_o = sync2_q & ~prev_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Generation-rate scheduler: phase accumulator, run/pause/step FSM and start/done handshake.
// Optional build macro OVERRUN_CNT_EN adds a saturating overrun counter output.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEFAULT,
    parameter int unsigned ACC_W  = ACC_W_DEFAULT
) (
    input  logic               cin,
    input  logic               rst_n,
    input  logic               btn_speed,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               gen_done,
    output logic               gen_start,
    output logic               running,
    output logic               busy,
    output logic [SPEED_W-1:0] speed_idx,
    output logic [FPS_W-1:0]   fps_out,
    output logic               overrun
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic speed_rise_c;
    logic run_rise_c;
    logic step_rise_c;

    btn_edge_sync u_sync_speed (.cin(cin), .rst_n(rst_n), .btn_i(btn_speed), .rise_c_o(speed_rise_c));
    btn_edge_sync u_sync_run   (.cin(cin), .rst_n(rst_n), .btn_i(btn_run),   .rise_c_o(run_rise_c));
    btn_edge_sync u_sync_step  (.cin(cin), .rst_n(rst_n), .btn_i(btn_step),  .rise_c_o(step_rise_c));

    state_e             state_q, state_d;
    logic               run_req_q, run_req_d;
    logic               busy_q, busy_d;
    logic               gen_start_q, gen_start_d;
    logic               overrun_q, overrun_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [FPS_W-1:0]   fps_q, fps_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   sum_c;
    logic               tick_c;

    // Phase accumulator: advances only while running, wraps modulo PERIOD.
    always_comb begin
        sum_c  = SUM_W'(acc_q) + SUM_W'(fps_q);
        tick_c = run_req_q && (sum_c >= SUM_W'(PERIOD));
        acc_d  = acc_q;
        if (run_req_q) begin
            acc_d = tick_c ? ACC_W'(sum_c - SUM_W'(PERIOD)) : ACC_W'(sum_c);
        end
    end

    // Speed index with wrap; fps tracks the new index in the same cycle.
    always_comb begin
        speed_d = speed_q;
        if (speed_rise_c) begin
            speed_d = (speed_q == SPEED_W'(SPEED_LAST)) ? '0 : speed_q + SPEED_W'(1);
        end
        fps_d = speed_inc(speed_d);
    end

    always_comb begin
        state_d     = state_q;
        run_req_d   = run_req_q;
        gen_start_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            PAUSED: begin
                if (run_rise_c) begin
                    state_d   = RUN_WAIT;
                    run_req_d = 1'b1;
                end else if (step_rise_c) begin
                    state_d     = BUSY;
                    gen_start_d = 1'b1;
                end
            end
            RUN_WAIT: begin
                // A pause request beats a coincident tick.
                if (run_rise_c) begin
                    state_d   = PAUSED;
                    run_req_d = 1'b0;
                end else if (tick_c) begin
                    state_d     = BUSY;
                    gen_start_d = 1'b1;
                end
            end
            BUSY: begin
                overrun_d = tick_c;
                if (run_rise_c) begin
                    run_req_d = ~run_req_q;
                end
                if (gen_done) begin
                    state_d = run_req_d ? RUN_WAIT : PAUSED;
                end
            end
            default: begin
                state_d   = PAUSED;
                run_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PAUSED;
            run_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            gen_start_q <= 1'b0;
            overrun_q   <= 1'b0;
            speed_q     <= '0;
            fps_q       <= FPS_W'(1);
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_req_q   <= run_req_d;
            busy_q      <= busy_d;
            gen_start_q <= gen_start_d;
            overrun_q   <= overrun_d;
            speed_q     <= speed_d;
            fps_q       <= fps_d;
            acc_q       <= acc_d;
        end
    end

`ifdef OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating count of dropped ticks; a speed change starts a fresh count.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (speed_rise_c) begin
            ovr_cnt_d = '0;
        end else if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

    assign gen_start = gen_start_q;
    assign running   = run_req_q;
    assign busy      = busy_q;
    assign speed_idx = speed_q;
    assign fps_out   = fps_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with PERIOD = 100 and a delay-programmable engine model.
module tb_game_tick_scheduler;

    logic       cin       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_run   = 1'b0;
    logic       btn_step  = 1'b0;
    logic       gen_done  = 1'b0;
    logic       gen_start;
    logic       running;
    logic       busy;
    logic [3:0] speed_idx;
    logic [7:0] fps_out;
    logic       overrun;
`ifdef OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int eng_dly     = 2;
    bit eng_en      = 1'b1;
    int eng_cnt     = 0;
    bit inject_done = 1'b0;

    logic [7:0] exp_fps [10] = '{8'd1, 8'd3, 8'd5, 8'd9, 8'd15, 8'd31, 8'd63, 8'd127, 8'd199, 8'd255};

    game_tick_scheduler #(.PERIOD(100), .ACC_W(32)) dut (
        .cin(cin), .rst_n(rst_n),
        .btn_speed(btn_speed), .btn_run(btn_run), .btn_step(btn_step),
        .gen_done(gen_done), .gen_start(gen_start), .running(running), .busy(busy),
        .speed_idx(speed_idx), .fps_out(fps_out), .overrun(overrun)
`ifdef OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 cin = ~cin;

    // Engine model: gen_done is sampled eng_dly posedges after the gen_start edge.
    always @(negedge cin) begin
        gen_done = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
        end else if (inject_done) begin
            gen_done    = 1'b1;
            inject_done = 1'b0;
        end else if (gen_start === 1'b1 && eng_en) begin
            if (eng_dly <= 1) gen_done = 1'b1;
            else              eng_cnt  = eng_dly - 1;
        end else if (eng_cnt != 0) begin
            eng_cnt--;
            if (eng_cnt == 0) gen_done = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge cin);
        rst_n = 1'b0; btn_speed = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        repeat (2) @(negedge cin);
        rst_n = 1'b1;
        @(negedge cin);
    endtask

    task automatic press(input bit s, input bit r, input bit t);
        @(negedge cin);
        btn_speed = s; btn_run = r; btn_step = t;
        @(negedge cin);
        btn_speed = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        repeat (3) @(negedge cin);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (running !== 1'b0)   begin n_err++; $display("FAIL rst_running: got %b want 0", running); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (gen_start !== 1'b0) begin n_err++; $display("FAIL rst_gen_start: got %b want 0", gen_start); end
        n_cmp++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        n_cmp++; if (speed_idx !== 4'd0) begin n_err++; $display("FAIL rst_speed_idx: got %0d want 0", speed_idx); end
        n_cmp++; if (fps_out !== 8'd1)   begin n_err++; $display("FAIL rst_fps: got %0d want 1", fps_out); end
    endtask

    task automatic test_rate();
        int first_gs, last_gs, n_gs, bad_int, n_ov;
        first_gs = -1; last_gs = -1; n_gs = 0; bad_int = 0; n_ov = 0;
        do_reset();
        eng_en = 1'b1; eng_dly = 2;
        @(negedge cin);
        btn_run = 1'b1;
        for (int c = 1; c <= 320; c++) begin
            @(negedge cin);
            if (c == 1) btn_run = 1'b0;
            if (c == 2) begin
                n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL run_edge2: got %b want 0", running); end
            end
            if (c == 3) begin
                n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run_edge3: got %b want 1", running); end
            end
            if (c == 103) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rate_busy_on: got %b want 1", busy); end
            end
            if (c == 105) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rate_busy_off: got %b want 0", busy); end
            end
            if (gen_start === 1'b1) begin
                n_gs++;
                if (first_gs < 0) first_gs = c;
                else if (c - last_gs != 100) bad_int++;
                last_gs = c;
            end
            if (overrun === 1'b1) n_ov++;
        end
        n_cmp++; if (first_gs != 103) begin n_err++; $display("FAIL rate_first_start: got cycle %0d want 103", first_gs); end
        n_cmp++; if (n_gs != 3)       begin n_err++; $display("FAIL rate_start_count: got %0d want 3", n_gs); end
        n_cmp++; if (bad_int != 0)    begin n_err++; $display("FAIL rate_interval: got %0d bad intervals want 0", bad_int); end
        n_cmp++; if (n_ov != 0)       begin n_err++; $display("FAIL rate_overrun: got %0d pulses want 0", n_ov); end
    endtask

    task automatic test_speed();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            press(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (speed_idx !== 4'(i % 10) || fps_out !== exp_fps[i % 10]) begin
                n_err++;
                $display("FAIL speed_press%0d: got idx %0d fps %0d want idx %0d fps %0d",
                         i, speed_idx, fps_out, i % 10, exp_fps[i % 10]);
            end
        end
        @(negedge cin);
        btn_speed = 1'b1;
        repeat (10) @(negedge cin);
        btn_speed = 1'b0;
        repeat (4) @(negedge cin);
        n_cmp++; if (speed_idx !== 4'd1 || fps_out !== 8'd3) begin
            n_err++; $display("FAIL speed_held: got idx %0d fps %0d want idx 1 fps 3", speed_idx, fps_out);
        end
    endtask

    task automatic test_overrun();
        int gs1, gs2, n_ov;
        gs1 = -1; gs2 = -1; n_ov = 0;
        do_reset();
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0);
        eng_en = 1'b1; eng_dly = 5;
        @(negedge cin);
        btn_run = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge cin);
            if (c == 1) btn_run = 1'b0;
            if (gen_start === 1'b1) begin
                if (gs1 < 0) gs1 = c;
                else if (gs2 < 0) gs2 = c;
            end
            if (c == 4 || c == 10) begin
                n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_at_start%0d: got %b want 0", c, overrun); end
            end
            if (c > 4 && c < 10 && overrun === 1'b1) n_ov++;
            if (c == 9) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_busy_release: got %b want 0", busy); end
`ifdef OVERRUN_CNT_EN
                n_cmp++; if (overrun_cnt !== 8'd5) begin n_err++; $display("FAIL ovr_cnt: got %0d want 5", overrun_cnt); end
`endif
            end
        end
        n_cmp++; if (gs1 != 4)  begin n_err++; $display("FAIL ovr_first_start: got %0d want 4", gs1); end
        n_cmp++; if (gs2 != 10) begin n_err++; $display("FAIL ovr_second_start: got %0d want 10", gs2); end
        n_cmp++; if (n_ov != 5) begin n_err++; $display("FAIL ovr_pulses: got %0d want 5", n_ov); end
    endtask

    task automatic test_step();
        int n_gs;
        n_gs = 0;
        do_reset();
        eng_en = 1'b1; eng_dly = 2;
        @(negedge cin);
        btn_step = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge cin);
            if (c == 1) btn_step = 1'b0;
            if (gen_start === 1'b1) n_gs++;
            if (c == 2) begin
                n_cmp++; if (gen_start !== 1'b0) begin n_err++; $display("FAIL step_edge2: got %b want 0", gen_start); end
            end
            if (c == 3) begin
                n_cmp++; if (gen_start !== 1'b1 || busy !== 1'b1 || running !== 1'b0) begin
                    n_err++; $display("FAIL step_edge3: got start %b busy %b run %b want 1 1 0", gen_start, busy, running);
                end
            end
            if (c == 4) begin
                n_cmp++; if (gen_start !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL step_edge4: got start %b busy %b want 0 1", gen_start, busy);
                end
            end
            if (c == 5) begin
                n_cmp++; if (busy !== 1'b0 || running !== 1'b0) begin
                    n_err++; $display("FAIL step_done: got busy %b run %b want 0 0", busy, running);
                end
            end
        end
        n_cmp++; if (n_gs != 1) begin n_err++; $display("FAIL step_pulse_count: got %0d want 1", n_gs); end

        press(1'b0, 1'b1, 1'b0);
        n_gs = 0;
        @(negedge cin);
        btn_step = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge cin);
            if (c == 1) btn_step = 1'b0;
            if (gen_start === 1'b1) n_gs++;
        end
        n_cmp++; if (n_gs != 0) begin n_err++; $display("FAIL step_while_running: got %0d starts want 0", n_gs); end

        do_reset();
        n_gs = 0;
        @(negedge cin);
        btn_run = 1'b1; btn_step = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge cin);
            if (c == 1) begin btn_run = 1'b0; btn_step = 1'b0; end
            if (gen_start === 1'b1) n_gs++;
        end
        n_cmp++; if (running !== 1'b1 || n_gs != 0) begin
            n_err++; $display("FAIL run_step_same: got run %b starts %0d want 1 0", running, n_gs);
        end
    endtask

    task automatic test_pause_in_busy();
        int ok_first, late_gs;
        ok_first = 0; late_gs = 0;
        do_reset();
        eng_en = 1'b1; eng_dly = 10;
        @(negedge cin);
        btn_run = 1'b1;
        for (int c = 1; c <= 1203; c++) begin
            @(negedge cin);
            if (c == 1)   btn_run = 1'b0;
            if (c == 104) btn_run = 1'b1;
            if (c == 105) btn_run = 1'b0;
            if (gen_start === 1'b1) begin
                if (c == 103) ok_first = 1;
                else late_gs++;
            end
            if (c == 106) begin
                n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL pib_run_before: got %b want 1", running); end
            end
            if (c == 107) begin
                n_cmp++; if (running !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL pib_toggle: got run %b busy %b want 0 1", running, busy);
                end
            end
            if (c == 112) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pib_still_busy: got %b want 1", busy); end
            end
            if (c == 113) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pib_done: got %b want 0", busy); end
            end
        end
        n_cmp++; if (ok_first != 1) begin n_err++; $display("FAIL pib_first_start: got %0d want 1", ok_first); end
        n_cmp++; if (late_gs != 0)  begin n_err++; $display("FAIL pib_no_more_starts: got %0d want 0", late_gs); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL pib_final_run: got %b want 0", running); end
    endtask

    task automatic test_async_reset();
        int n_gs;
        n_gs = 0;
        do_reset();
        eng_en = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        n_cmp++; if (busy !== 1'b1 || running !== 1'b1 || speed_idx !== 4'd2) begin
            n_err++; $display("FAIL ar_pre: got busy %b run %b idx %0d want 1 1 2", busy, running, speed_idx);
        end
        @(negedge cin);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || running !== 1'b0 || gen_start !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL ar_ctrl: got busy %b run %b start %b ovr %b want 0 0 0 0", busy, running, gen_start, overrun);
        end
        n_cmp++; if (speed_idx !== 4'd0 || fps_out !== 8'd1) begin
            n_err++; $display("FAIL ar_speed: got idx %0d fps %0d want 0 1", speed_idx, fps_out);
        end
        @(negedge cin);
        rst_n = 1'b1;
        repeat (3) @(negedge cin);
        inject_done = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge cin);
            if (gen_start === 1'b1) n_gs++;
        end
        n_cmp++; if (busy !== 1'b0 || running !== 1'b0 || n_gs != 0) begin
            n_err++; $display("FAIL ar_stray_done: got busy %b run %b starts %0d want 0 0 0", busy, running, n_gs);
        end
        press(1'b0, 1'b1, 1'b0);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL ar_restart: got %b want 1", running); end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_speed();
        test_overrun();
        test_step();
        test_pause_in_busy();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
